y86_bus_arbiter: RTL and testbench

- Shares the single y86 memory bus (bus_A/bus_in/bus_out/bus_WE/bus_RE) between two masters.
- Master 0 is the y86_seq core; master 1 is a loader/debug/DMA port.
- Round-robin arbitration, one outstanding transfer at a time, wait-state support via bus_ready, and a timeout that forces completion with an error flag.
- Sits between the masters and the memory model/controller.

---
 rtl/y86_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_y86_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_bus_arbiter.sv
// Two-master round-robin arbiter for the y86 memory bus: one transfer in flight,
// wait states via bus_ready, and a timeout that completes the transfer with err.
module y86_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_A,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_A,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        err,
  output logic [31:0] bus_A,
  output logic [31:0] bus_out,
  output logic        bus_WE,
  output logic        bus_RE,
  input  logic [31:0] bus_in,
  input  logic        bus_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             last_gnt;
  logic             gnt;
  logic [CNT_W-1:0] cnt;

  logic             any_req;
  logic             sel;
  logic             sel_we;
  logic [31:0]      sel_A;
  logic [31:0]      sel_wdata;

  // On a tie the master that did not win last time is granted.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) sel = ~last_gnt;
    else                  sel = m1_req;
    sel_we    = sel ? m1_we    : m0_we;
    sel_A     = sel ? m1_A     : m0_A;
    sel_wdata = sel ? m1_wdata : m0_wdata;
  end

  // The bus registers double as the latched request of the granted master.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      err      <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      bus_A    <= '0;
      bus_out  <= '0;
      bus_WE   <= 1'b0;
      bus_RE   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          err    <= 1'b0;
          if (any_req) begin
            gnt      <= sel;
            last_gnt <= sel;
            cnt      <= '0;
            bus_A    <= sel_A;
            bus_out  <= sel_we ? sel_wdata : 32'd0;
            bus_WE   <= sel_we;
            bus_RE   <= ~sel_we;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // bus_ready takes priority over a timeout landing on the same cycle.
          if (bus_ready || cnt == CNT_LAST) begin
            if (bus_ready && bus_RE) begin
              if (gnt) m1_rdata <= bus_in;
              else     m0_rdata <= bus_in;
            end
            err     <= ~bus_ready;
            m0_ack  <= ~gnt;
            m1_ack  <= gnt;
            bus_A   <= '0;
            bus_out <= '0;
            bus_WE  <= 1'b0;
            bus_RE  <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          err    <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Bench for y86_bus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grant order, timing, err and read data.
module tb_y86_bus_arbiter;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_A = '0, m0_wdata = '0, m1_A = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, err, bus_WE, bus_RE;
  logic [31:0] m0_rdata, m1_rdata, bus_A, bus_out;
  logic [31:0] bus_in = '0;
  logic        bus_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_win;
  logic [31:0] exp_rd [2];

  y86_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_A(m0_A), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_A(m1_A), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .err(err), .bus_A(bus_A), .bus_out(bus_out), .bus_WE(bus_WE), .bus_RE(bus_RE),
    .bus_in(bus_in), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({m0_ack, m1_ack, err, bus_WE, bus_RE} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {m0_ack, m1_ack, err, bus_WE, bus_RE});
    end
    tick;
    tick;
    checks++;
    if ({bus_A, bus_out, m0_rdata, m1_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {bus_A, bus_out, m0_rdata, m1_rdata});
    end
    #2 rst = 1'b1;
    tick;
    last_win  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({m0_ack, m1_ack, err, bus_WE, bus_RE, bus_A} !== 37'd0) begin
        errors++;
        $display("FAIL idle cycle %0d got %h want 0", i, {m0_ack, m1_ack, err, bus_WE, bus_RE, bus_A});
      end
      tick;
    end
  endtask

  task automatic test_single_read;
    m0_req = 1'b1; m0_we = 1'b0; m0_A = 32'h10;
    tick;
    checks++;
    if ({bus_RE, bus_WE, bus_A, bus_out, m0_ack} !== {2'b10, 32'h10, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL read_busy got RE=%b WE=%b A=%h out=%h ack=%b want RE=1 WE=0 A=10 out=0 ack=0",
               bus_RE, bus_WE, bus_A, bus_out, m0_ack);
    end
    bus_ready = 1'b1; bus_in = 32'hDEADBEEF;
    tick;
    checks++;
    if ({m0_ack, m1_ack, err, bus_RE, bus_A} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL read_done got ack0=%b ack1=%b err=%b RE=%b A=%h want 1 0 0 0 0",
               m0_ack, m1_ack, err, bus_RE, bus_A);
    end
    checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data got %h want deadbeef", m0_rdata);
    end
    m0_req = 1'b0; bus_ready = 1'b0;
    tick;
    checks++;
    if (m0_ack !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_pulse got ack=%b err=%b want 0 0", m0_ack, err);
    end
    last_win = 0; exp_rd[0] = 32'hDEADBEEF;
  endtask

  task automatic test_wait_write;
    int we_cycles = 0;
    m1_req = 1'b1; m1_we = 1'b1; m1_A = 32'h20; m1_wdata = 32'h55;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (bus_WE) we_cycles++;
      checks++;
      if ({bus_WE, bus_RE, bus_A, bus_out, m1_ack} !== {2'b10, 32'h20, 32'h55, 1'b0}) begin
        errors++;
        $display("FAIL write_busy%0d got WE=%b RE=%b A=%h out=%h ack=%b want 1 0 20 55 0",
                 i, bus_WE, bus_RE, bus_A, bus_out, m1_ack);
      end
      bus_ready = (i == 3); bus_in = 32'h12345678;
      tick;
    end
    if (bus_WE) we_cycles++;
    checks++;
    if (we_cycles !== 4) begin
      errors++;
      $display("FAIL write_we_len got %0d want 4", we_cycles);
    end
    checks++;
    if ({m1_ack, m0_ack, err} !== 3'b100 || m1_rdata !== exp_rd[1]) begin
      errors++;
      $display("FAIL write_done got ack1=%b ack0=%b err=%b rdata=%h want 1 0 0 %h",
               m1_ack, m0_ack, err, m1_rdata, exp_rd[1]);
    end
    m1_req = 1'b0; bus_ready = 1'b0;
    tick;
    last_win = 1;
  endtask

  task automatic test_contention;
    int exp_m, ack_cyc, prev_cyc;
    logic [31:0] din;
    m0_req = 1'b1; m0_we = 1'b0; m0_A = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_A = 32'h200;
    bus_ready = 1'b1;
    prev_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      exp_m = 1 - last_win;
      tick;
      checks++;
      if (bus_A !== (exp_m ? 32'h200 : 32'h100) || bus_RE !== 1'b1) begin
        errors++;
        $display("FAIL contend_grant%0d got A=%h RE=%b want master %0d", n, bus_A, bus_RE, exp_m);
      end
      din = $urandom; bus_in = din;
      tick;
      ack_cyc = cyc;
      exp_rd[exp_m] = din;
      last_win = exp_m;
      checks++;
      if ({m1_ack, m0_ack} !== (exp_m ? 2'b10 : 2'b01) || err !== 1'b0) begin
        errors++;
        $display("FAIL contend_ack%0d got ack1=%b ack0=%b err=%b want master %0d", n, m1_ack, m0_ack, err, exp_m);
      end
      checks++;
      if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        errors++;
        $display("FAIL contend_data%0d got %h %h want %h %h", n, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
      end
      if (n > 0) begin
        checks++;
        if (ack_cyc - prev_cyc !== 3) begin
          errors++;
          $display("FAIL contend_rate%0d got %0d cycles want 3", n, ack_cyc - prev_cyc);
        end
      end
      prev_cyc = ack_cyc;
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    int nbusy = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_A = 32'h30; bus_ready = 1'b0; bus_in = 32'hFFFF0000;
    tick;
    while (bus_RE && nbusy < 40) begin
      nbusy++;
      tick;
    end
    checks++;
    if (nbusy !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len got %0d want %0d", nbusy, TIMEOUT);
    end
    checks++;
    if ({m0_ack, m1_ack, err} !== 3'b101 || m0_rdata !== exp_rd[0]) begin
      errors++;
      $display("FAIL timeout_done got ack0=%b ack1=%b err=%b rdata=%h want 1 0 1 %h",
               m0_ack, m1_ack, err, m0_rdata, exp_rd[0]);
    end
    m0_req = 1'b0;
    tick;
    m1_req = 1'b1; m1_we = 1'b0; m1_A = 32'h34;
    tick;
    for (int i = 0; i < TIMEOUT; i++) begin
      bus_ready = (i == TIMEOUT - 1); bus_in = 32'hCAFEF00D;
      tick;
    end
    checks++;
    if ({m1_ack, m0_ack, err} !== 3'b100 || m1_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL timeout_edge got ack1=%b ack0=%b err=%b rdata=%h want 1 0 0 cafef00d",
               m1_ack, m0_ack, err, m1_rdata);
    end
    m1_req = 1'b0; bus_ready = 1'b0;
    tick;
    exp_rd[1] = 32'hCAFEF00D; last_win = 1;
  endtask

  task automatic test_async_reset;
    int acks = 0;
    m1_req = 1'b1; m1_we = 1'b1; m1_A = 32'h40; m1_wdata = 32'hA5A5;
    tick;
    checks++;
    if (bus_WE !== 1'b1 || bus_A !== 32'h40) begin
      errors++;
      $display("FAIL arst_pre got WE=%b A=%h want 1 40", bus_WE, bus_A);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus_WE, bus_RE, bus_A, bus_out} !== 66'd0) begin
      errors++;
      $display("FAIL arst_drop got WE=%b RE=%b A=%h out=%h want 0", bus_WE, bus_RE, bus_A, bus_out);
    end
    m1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (m0_ack || m1_ack) acks++;
    end
    #2 rst = 1'b1;
    last_win = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_A = 32'h50;
    m1_req = 1'b1; m1_we = 1'b0; m1_A = 32'h60;
    tick;
    if (m0_ack || m1_ack) acks++;
    checks++;
    if (bus_A !== 32'h50) begin
      errors++;
      $display("FAIL arst_tie got A=%h want 50", bus_A);
    end
    bus_ready = 1'b1; bus_in = 32'h0BADF00D;
    tick;
    checks++;
    if (acks !== 0 || {m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL arst_after got stray=%0d ack0=%b ack1=%b rdata=%h want 0 1 0 0badf00d",
               acks, m0_ack, m1_ack, m0_rdata);
    end
    m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
    tick;
    last_win = 0; exp_rd[0] = 32'h0BADF00D;
  endtask

  task automatic test_random;
    logic        pend [2];
    logic        pwe  [2];
    logic [31:0] pa   [2];
    logic [31:0] pd   [2];
    int          win, w, busy_len, m;
    logic        exp_err;
    logic [31:0] din;
    pend[0] = 1'b0; pend[1] = 1'b0;
    din = '0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1; pwe[k] = 1'($urandom_range(0, 1)); pa[k] = $urandom; pd[k] = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        m = $urandom_range(0, 1);
        pend[m] = 1'b1; pwe[m] = 1'($urandom_range(0, 1)); pa[m] = $urandom; pd[m] = $urandom;
      end
      m0_req = pend[0]; m0_we = pwe[0]; m0_A = pa[0]; m0_wdata = pd[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_A = pa[1]; m1_wdata = pd[1];
      win = (pend[0] && pend[1]) ? 1 - last_win : (pend[1] ? 1 : 0);
      last_win = win;
      w = $urandom_range(0, TIMEOUT + 1);
      busy_len = (w < TIMEOUT) ? w + 1 : TIMEOUT;
      exp_err  = (w >= TIMEOUT);
      tick;
      for (int i = 0; i < busy_len; i++) begin
        checks++;
        if ({bus_WE, bus_RE, bus_A, bus_out, m0_ack, m1_ack} !==
            {pwe[win], ~pwe[win], pa[win], (pwe[win] ? pd[win] : 32'd0), 2'b00}) begin
          errors++;
          $display("FAIL rand%0d busy%0d got WE=%b RE=%b A=%h out=%h want master %0d A=%h",
                   n, i, bus_WE, bus_RE, bus_A, bus_out, win, pa[win]);
        end
        din = $urandom; bus_in = din; bus_ready = (i == w);
        tick;
      end
      if (!pwe[win] && !exp_err) exp_rd[win] = din;
      checks++;
      if ({m1_ack, m0_ack} !== (win ? 2'b10 : 2'b01) || err !== exp_err ||
          m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1] || bus_WE !== 1'b0 || bus_RE !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d done got ack1=%b ack0=%b err=%b rd=%h,%h want master %0d err=%b rd=%h,%h",
                 n, m1_ack, m0_ack, err, m0_rdata, m1_rdata, win, exp_err, exp_rd[0], exp_rd[1]);
      end
      pend[win] = 1'b0;
      if (win == 1) m1_req = 1'b0; else m0_req = 1'b0;
      bus_ready = 1'($urandom_range(0, 1));
      tick;
      checks++;
      if ({m0_ack, m1_ack, err, bus_WE, bus_RE} !== 5'b0) begin
        errors++;
        $display("FAIL rand%0d idle got %b want 00000", n, {m0_ack, m1_ack, err, bus_WE, bus_RE});
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single_read;
    test_wait_write;
    test_contention;
    test_timeout;
    test_async_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
